io_output_bank: RTL

- Parametrised memory-mapped output register bank; successor to the fixed six-port output register.
- Sits on the CPU data bus behind the I/O write decode and drives LEDs, 7-segment displays and other board outputs.
- Adds configurable port count and width, byte enables, and set/clear/pulse alias addresses with timed auto-clear.
- Adds registered readback and per-port change strobes.

---
 rtl/io_output_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/io_output_bank.sv
// Memory-mapped output register bank with write/set/clear/pulse aliases,
// byte enables, timed pulse auto-clear, registered readback and change strobes.
module io_output_bank #(
    parameter int NPORTS    = 6,
    parameter int DATA_W    = 32,
    parameter int BASE_IDX  = 32,
    parameter int PULSE_CYC = 4
) (
    input  logic                     io_clk,
    input  logic                     clr,
    input  logic [31:0]              addr,
    input  logic [DATA_W-1:0]        datain,
    input  logic [DATA_W/8-1:0]      be,
    input  logic                     write_io_enable,
    output logic [NPORTS*DATA_W-1:0] out_ports,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NPORTS-1:0]        changed
);

    localparam int NB = DATA_W / 8;
    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(PULSE_CYC - 1);
    localparam logic [5:0] BASE = BASE_IDX[5:0];
    localparam logic [3:0] NP = 4'(NPORTS);

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_SET   = 2'd1,
        OP_CLEAR = 2'd2,
        OP_PULSE = 2'd3
    } op_e;

    logic [DATA_W-1:0] val_q   [NPORTS];
    logic [DATA_W-1:0] val_d   [NPORTS];
    logic [DATA_W-1:0] pmask_q [NPORTS];
    logic [DATA_W-1:0] pmask_d [NPORTS];
    logic [CW-1:0]     cnt_q   [NPORTS];
    logic [CW-1:0]     cnt_d   [NPORTS];
    logic [NPORTS-1:0] act_q;
    logic [NPORTS-1:0] act_d;
    logic [NPORTS-1:0] chg_d;
    logic [DATA_W-1:0] rd_d;

    logic [6:0]        diff;
    logic              hit;
    logic              wr_hit;
    op_e               op;
    logic [2:0]        sel;
    logic [DATA_W-1:0] bemask;
    logic [DATA_W-1:0] m;
    logic              unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};

    // Offset from the base index: bits [4:3] pick the alias, [2:0] the port.
    always_comb begin
        diff = {1'b0, addr[7:2]} - {1'b0, BASE};
        op   = op_e'(diff[4:3]);
        sel  = diff[2:0];
        hit  = !diff[6] && !diff[5] && ({1'b0, sel} < NP);
        wr_hit = write_io_enable && hit;
    end

    always_comb begin
        bemask = '0;
        for (int b = 0; b < NB; b++) begin
            bemask[8*b +: 8] = {8{be[b]}};
        end
        m = datain & bemask;
    end

    // Expiry is resolved first so a same-edge write lands on top of it.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NPORTS; i++) begin
            val_d[i]   = val_q[i];
            pmask_d[i] = pmask_q[i];
            cnt_d[i]   = cnt_q[i];
            act_d[i]   = act_q[i];
            if (act_q[i]) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    val_d[i]   = val_q[i] & ~pmask_q[i];
                    pmask_d[i] = '0;
                    act_d[i]   = 1'b0;
                end
            end
            if (wr_hit && sel == 3'(i)) begin
                unique case (op)
                    OP_WRITE: val_d[i] = (val_d[i] & ~bemask) | m;
                    OP_SET:   val_d[i] = val_d[i] | m;
                    OP_CLEAR: val_d[i] = val_d[i] & ~m;
                    OP_PULSE: begin
                        val_d[i]   = val_d[i] | m;
                        pmask_d[i] = pmask_d[i] | m;
                        cnt_d[i]   = RELOAD;
                        act_d[i]   = 1'b1;
                    end
                endcase
            end
            chg_d[i] = (val_d[i] != val_q[i]);
            if (hit && sel == 3'(i)) begin
                rd_d = val_q[i];
            end
        end
    end

    always_ff @(posedge io_clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NPORTS; i++) begin
                val_q[i]   <= '0;
                pmask_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            act_q   <= '0;
            rd_data <= '0;
            changed <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                val_q[i]   <= val_d[i];
                pmask_q[i] <= pmask_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            act_q   <= act_d;
            rd_data <= rd_d;
            changed <= chg_d;
        end
    end

    always_comb begin
        out_ports = '0;
        for (int i = 0; i < NPORTS; i++) begin
            out_ports[i*DATA_W +: DATA_W] = val_q[i];
        end
    end

endmodule
